sequence_stage: RTL and testbench



---
 rtl/stage_pkg.sv | 16 +
 rtl/lfsr_galois.sv | 31 +++
 rtl/sequence_stage.sv | 160 ++++++++++++++++
 tb/tb_sequence_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// Shared types and LFSR helper for the sequence stage.
package stage_pkg;

   typedef enum logic [2:0] {StIdle, StGen, StArmed, StPass, StFail} stage_state_e;

   localparam int unsigned LfsrMaxW        = 64;
   localparam logic [15:0] DefaultLfsrTaps = 16'hB400;
   localparam logic [15:0] DefaultSeed     = 16'hACE1;

   // Galois right-shift step; callers zero-extend narrower states.
   function automatic logic [LfsrMaxW-1:0] lfsr_next(input logic [LfsrMaxW-1:0] state,
                                                     input logic [LfsrMaxW-1:0] taps);
      return (state >> 1) ^ (state[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Loadable Galois LFSR; load has priority over step.
module lfsr_galois
   import stage_pkg::*;
#(
   parameter int unsigned       LFSR_W = 16,
   parameter logic [LFSR_W-1:0] TAPS   = DefaultLfsrTaps,
   parameter logic [LFSR_W-1:0] SEED   = DefaultSeed
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] value_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= SEED;
      end else if (load) begin
         value_q <= load_val;
      end else if (step) begin
         value_q <= LFSR_W'(lfsr_next(LfsrMaxW'(value_q), LfsrMaxW'(TAPS)));
      end
   end

   assign value = value_q;

endmodule

// File: rtl/sequence_stage.sv
// Bomb-lab sequence stage: generates a code table from an LFSR, then checks presses in order.
module sequence_stage
   import stage_pkg::*;
#(
   parameter int unsigned       SEQ_LEN      = 8,
   parameter int unsigned       CODE_W       = 4,
   parameter int unsigned       LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS    = DefaultLfsrTaps,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = DefaultSeed,
   parameter int unsigned       MAX_STRIKES  = 3,
   parameter int unsigned       TIMEOUT_CYC  = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [LFSR_W-1:0]                seed_in,
   input  logic                             btn_valid,
   input  logic [CODE_W-1:0]                btn_code,
   output logic                             busy,
   output logic                             armed,
   output logic [$clog2(SEQ_LEN+1)-1:0]     progress,
   output logic [$clog2(MAX_STRIKES+1)-1:0] strikes,
   output logic [CODE_W-1:0]                exp_code,
   output logic                             success,
   output logic                             failure
);

   localparam int unsigned IdxW   = $clog2(SEQ_LEN);
   localparam int unsigned ProgW  = $clog2(SEQ_LEN + 1);
   localparam int unsigned StrW   = $clog2(MAX_STRIKES + 1);
   localparam int unsigned TimerW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

   stage_state_e      state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [ProgW-1:0]  progress_q, progress_d;
   logic [StrW-1:0]   strikes_q, strikes_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [CODE_W-1:0] exp_code_q, exp_code_d;
   logic [CODE_W-1:0] seq_table_q [SEQ_LEN-1:0];

   logic              lfsr_load, lfsr_step, do_start, strike;
   logic [LFSR_W-1:0] lfsr_val, lfsr_seed;
   logic [CODE_W-1:0] gen_code;

   assign lfsr_seed = (seed_in == '0) ? DEFAULT_SEED : seed_in;
   // Table entry is the post-step LFSR value, matching what the LFSR holds next cycle.
   assign gen_code  = CODE_W'(lfsr_next(LfsrMaxW'(lfsr_val), LfsrMaxW'(LFSR_TAPS)));

   lfsr_galois #(
      .LFSR_W (LFSR_W),
      .TAPS   (LFSR_TAPS),
      .SEED   (DEFAULT_SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (lfsr_seed),
      .step     (lfsr_step),
      .value    (lfsr_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         progress_q <= '0;
         strikes_q  <= '0;
         timer_q    <= '0;
         exp_code_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         progress_q <= progress_d;
         strikes_q  <= strikes_d;
         timer_q    <= timer_d;
         exp_code_q <= exp_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q == StGen) begin
         seq_table_q[idx_q] <= gen_code;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      progress_d = progress_q;
      strikes_d  = strikes_q;
      timer_d    = timer_q;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      strike     = 1'b0;
      do_start   = start && (state_q != StGen);
      if (do_start) begin
         state_d    = StGen;
         idx_d      = '0;
         progress_d = '0;
         strikes_d  = '0;
         timer_d    = '0;
         lfsr_load  = 1'b1;
      end else begin
         unique case (state_q)
            StGen: begin
               lfsr_step = 1'b1;
               if (idx_q == IdxW'(SEQ_LEN - 1)) begin
                  idx_d   = '0;
                  state_d = StArmed;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
            StArmed: begin
               // A press wins over a coincident timer expiry.
               if (btn_valid) begin
                  timer_d = '0;
                  if (btn_code == exp_code_q) begin
                     progress_d = progress_q + ProgW'(1);
                     if (progress_q == ProgW'(SEQ_LEN - 1)) begin
                        state_d = StPass;
                     end
                  end else begin
                     strike = 1'b1;
                  end
               end else if (TIMEOUT_CYC != 0) begin
                  if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
                     timer_d = '0;
                     strike  = 1'b1;
                  end else begin
                     timer_d = timer_q + TimerW'(1);
                  end
               end
               if (strike) begin
                  progress_d = '0;
                  if (strikes_q >= StrW'(MAX_STRIKES - 1)) begin
                     strikes_d = StrW'(MAX_STRIKES);
                     state_d   = StFail;
                  end else begin
                     strikes_d = strikes_q + StrW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
      exp_code_d = (state_d == StArmed) ? seq_table_q[IdxW'(progress_d)] : '0;
   end

   always_comb begin
      busy     = (state_q == StGen);
      armed    = (state_q == StArmed);
      success  = (state_q == StPass);
      failure  = (state_q == StFail);
      progress = progress_q;
      strikes  = strikes_q;
      exp_code = exp_code_q;
   end

endmodule

// File: tb/tb_sequence_stage.sv
// Directed scoreboard bench for sequence_stage (timeout enabled at 20 cycles).
module tb_sequence_stage;

   localparam int MI = 0, MG = 1, MA = 2, MP = 3, MF = 4;

   logic        clk = 1'b0;
   logic        rst, start, btn_valid;
   logic [15:0] seed_in;
   logic [3:0]  btn_code;
   logic        busy, armed, success, failure;
   logic [3:0]  progress;
   logic [1:0]  strikes;
   logic [3:0]  exp_code;

   sequence_stage #(
      .SEQ_LEN      (8),
      .CODE_W       (4),
      .LFSR_W       (16),
      .LFSR_TAPS    (16'hB400),
      .DEFAULT_SEED (16'hACE1),
      .MAX_STRIKES  (3),
      .TIMEOUT_CYC  (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed_in   (seed_in),
      .btn_valid (btn_valid),
      .btn_code  (btn_code),
      .busy      (busy),
      .armed     (armed),
      .progress  (progress),
      .strikes   (strikes),
      .exp_code  (exp_code),
      .success   (success),
      .failure   (failure)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    progress;
      int    strikes;
      bit    success;
      bit    failure;
      bit    armed;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         m_progress, m_strikes, m_state;
   logic [3:0] ref_tab [8];

   task automatic check(input string tag, input logic [31:0] obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_ref(input logic [15:0] seed);
      logic [15:0] s;
      s = (seed == 16'h0) ? 16'hACE1 : seed;
      for (int i = 0; i < 8; i++) begin
         s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
         ref_tab[i] = s[3:0];
      end
   endtask

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag      = tag;
      e.progress = m_progress;
      e.strikes  = m_strikes;
      e.success  = (m_state == MP);
      e.failure  = (m_state == MF);
      e.armed    = (m_state == MA);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty observed 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      check($sformatf("%s_progress", e.tag), progress, e.progress);
      check($sformatf("%s_strikes", e.tag), strikes, e.strikes);
      check($sformatf("%s_success", e.tag), success, int'(e.success));
      check($sformatf("%s_failure", e.tag), failure, int'(e.failure));
      check($sformatf("%s_armed", e.tag), armed, int'(e.armed));
   endtask

   task automatic model_press(input logic [3:0] code);
      if (m_state == MA) begin
         if (code == ref_tab[m_progress]) begin
            m_progress++;
            if (m_progress == 8) m_state = MP;
         end else begin
            m_strikes++;
            m_progress = 0;
            if (m_strikes == 3) m_state = MF;
         end
      end
   endtask

   task automatic press(input logic [3:0] code, input string tag);
      btn_valid = 1'b1;
      btn_code  = code;
      model_press(code);
      push_exp(tag);
      tick();
      btn_valid = 1'b0;
      pop_check();
   endtask

   task automatic do_start(input logic [15:0] seed);
      start   = 1'b1;
      seed_in = seed;
      tick();
      start   = 1'b0;
      seed_in = '0;
      build_ref(seed);
      m_progress = 0;
      m_strikes  = 0;
      m_state    = MG;
   endtask

   task automatic wait_armed(input string tag);
      int n;
      n = 0;
      while (armed !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(tag, armed, 1);
      m_state = MA;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_armed"}, armed, 0);
      check({tag, "_progress"}, progress, 0);
      check({tag, "_strikes"}, strikes, 0);
      check({tag, "_exp_code"}, exp_code, 0);
      check({tag, "_success"}, success, 0);
      check({tag, "_failure"}, failure, 0);
      m_state    = MI;
      m_progress = 0;
      m_strikes  = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_code = '0; seed_in = '0;
      m_state = MI; m_progress = 0; m_strikes = 0;
      tick();
      tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      // Generation timing and default-seed table
      do_start(16'h0);
      for (int i = 0; i < 8; i++) begin
         check("gen_busy", busy, 1);
         check("gen_not_armed", armed, 0);
         tick();
      end
      check("armed_at_9", armed, 1);
      check("busy_drop", busy, 0);
      m_state = MA;

      for (int i = 0; i < 8; i++) begin
         check($sformatf("exp_code_%0d", i), exp_code, int'(ref_tab[i]));
         press(ref_tab[i], "seq");
         tick();
         tick();
      end
      press(ref_tab[0], "pass_ignore");
      check("pass_exp_code", exp_code, 0);

      // Strikes up to failure
      do_start(16'h0);
      wait_armed("armed_strike");
      for (int i = 0; i < 3; i++) press(ref_tab[i], "pre");
      press(ref_tab[3] ^ 4'h1, "wrong1");
      press(ref_tab[0] ^ 4'h1, "wrong2");
      press(ref_tab[0] ^ 4'h1, "wrong3");
      press(ref_tab[0], "fail_ignore");

      // Timeout boundary
      do_start(16'h0);
      wait_armed("armed_to");
      press(ref_tab[0], "to_first");
      repeat (19) tick();
      check("to_before_strikes", strikes, 0);
      check("to_before_progress", progress, 1);
      tick();
      m_strikes  = 1;
      m_progress = 0;
      push_exp("timeout");
      pop_check();
      repeat (19) tick();
      press(ref_tab[0], "press_on_expiry");

      // Abort mid-ARMED with a coincident press, then seeded table
      do_start(16'h0);
      wait_armed("armed_abort");
      for (int i = 0; i < 5; i++) press(ref_tab[i], "pre_abort");
      start = 1'b1; seed_in = 16'h1234; btn_valid = 1'b1; btn_code = ref_tab[5];
      tick();
      start = 1'b0; seed_in = '0; btn_valid = 1'b0;
      check("abort_progress", progress, 0);
      check("abort_strikes", strikes, 0);
      check("abort_busy", busy, 1);
      check("abort_armed", armed, 0);
      build_ref(16'h1234);
      m_progress = 0; m_strikes = 0; m_state = MG;
      wait_armed("armed_seeded");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("seeded_exp_code_%0d", i), exp_code, int'(ref_tab[i]));
         press(ref_tab[i], "seeded");
      end

      // Reset during GEN
      do_start(16'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_gen");
      press(ref_tab[0], "idle_ignore");
      check("idle_busy", busy, 0);

      // Reset during FAIL
      do_start(16'h0);
      wait_armed("armed_fail2");
      for (int i = 0; i < 3; i++) press(ref_tab[0] ^ 4'h2, "wrong_f");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_fail");
      press(ref_tab[0], "idle_ignore2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
